// File: rtl/seq_restoring_divider_if.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider_if
// Start/done handshake and operand/result bundle for the sequential restoring
// divider.
//   start        requester -> divider  request, sampled only while the divider is idle
//   dividend     requester -> divider  unsigned numerator
//   divisor      requester -> divider  unsigned denominator
//   busy         divider -> requester  high while quotient bits are being produced
//   done         divider -> requester  one-cycle pulse, results valid
//   quotient     divider -> requester  unsigned quotient, held until the next result
//   remainder    divider -> requester  unsigned remainder, held until the next result
//   div_by_zero  divider -> requester  captured divisor was zero
// master = requester side, slave = divider side.
// ----------------------------------------------------------------------------
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, overrides everything (aborts a division)
//   div_if  slave side of seq_restoring_divider_if (start/operands in,
//           busy/done/quotient/remainder/div_by_zero out)
// A nonzero-divisor division takes WIDTH CALC cycles plus one DONE cycle; a
// zero divisor goes straight to DONE with quotient all ones and remainder equal
// to the dividend.
// ----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave div_if
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Partial remainder; the extra compare bit only lives in rs below, since
    // the stored remainder is always below the divisor.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Shifted partial remainder, WIDTH+1 bits so the compare cannot overflow.
    logic [WIDTH:0]   rs;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        rs      = {r_q, q_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    if (div_if.divisor != '0) begin
                        dvs_d   = div_if.divisor;
                        r_d     = '0;
                        q_d     = div_if.dividend;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = div_if.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (rs >= {1'b0, dvs_q}) begin
                    // Difference is below the divisor, so WIDTH bits hold it exactly.
                    r_d = rs[WIDTH-1:0] - dvs_q;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = rs[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quo_d   = q_d;
                    rem_d   = r_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign div_if.busy        = (state_q == CALC);
    assign div_if.done        = (state_q == DONE);
    assign div_if.quotient    = quo_q;
    assign div_if.remainder   = rem_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_restoring_divider
// Directed bench for seq_restoring_divider (WIDTH = 4): single divisions,
// divide by zero, start during CALC, reset mid-CALC, and a sweep over all
// 256 operand pairs with start held high.
// ----------------------------------------------------------------------------
module tb_seq_restoring_divider;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt;
    int   overlap_cnt;

    seq_restoring_divider_if #(.WIDTH(WIDTH)) dif ();

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done pulses and done/busy overlap, sampled mid-cycle.
    always @(negedge clk) begin
        if (dif.done === 1'b1) done_cnt++;
        if (dif.done === 1'b1 && dif.busy === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, wait for done, return in IDLE.
    // lat = edges after the accepting edge until done is seen (0 for dbz).
    task automatic do_op(input logic [3:0] n, input logic [3:0] d,
                         output logic [3:0] q, output logic [3:0] r, output logic z,
                         output int lat, output int busy_cyc);
        dif.start    = 1'b1;
        dif.dividend = n;
        dif.divisor  = d;
        tick();
        dif.start    = 1'b0;
        // Scramble operands: they must not affect the running operation.
        dif.dividend = 4'($urandom);
        dif.divisor  = 4'($urandom);
        lat      = 0;
        busy_cyc = 0;
        while (dif.done !== 1'b1 && lat < 20) begin
            if (dif.busy === 1'b1) busy_cyc++;
            tick();
            lat++;
        end
        if (dif.done !== 1'b1) check("op_timeout", 0, 1);
        q = dif.quotient;
        r = dif.remainder;
        z = dif.div_by_zero;
        tick();
    endtask

    initial begin
        logic [3:0] q, r;
        logic       z;
        int         lat, bc, base;
        int         cyc, last_cyc, guard;
        int         ni, di, qi, ri;

        checks      = 0;
        errors      = 0;
        done_cnt    = 0;
        overlap_cnt = 0;
        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) tick();

        check("rst_busy", dif.busy, 0);
        check("rst_done", dif.done, 0);
        check("rst_q",    dif.quotient, 0);
        check("rst_r",    dif.remainder, 0);
        check("rst_dbz",  dif.div_by_zero, 0);
        rst = 1'b0;
        tick();

        // 13 / 3
        base = done_cnt;
        do_op(4'd13, 4'd3, q, r, z, lat, bc);
        check("t1_lat",  lat, 4);
        check("t1_busy", bc, 4);
        check("t1_q",    q, 4);
        check("t1_r",    r, 1);
        check("t1_dbz",  z, 0);
        check("t1_done_off", dif.done, 0);
        check("t1_pulses", done_cnt - base, 1);

        // 15 / 1 then 3 / 7
        base = done_cnt;
        do_op(4'd15, 4'd1, q, r, z, lat, bc);
        check("t2a_q", q, 15);
        check("t2a_r", r, 0);
        check("t2a_pulses", done_cnt - base, 1);
        base = done_cnt;
        do_op(4'd3, 4'd7, q, r, z, lat, bc);
        check("t2b_q", q, 0);
        check("t2b_r", r, 3);
        check("t2b_pulses", done_cnt - base, 1);

        // 5 / 0
        do_op(4'd5, 4'd0, q, r, z, lat, bc);
        check("t3_lat",  lat, 0);
        check("t3_busy", bc, 0);
        check("t3_dbz",  z, 1);
        check("t3_q",    q, 15);
        check("t3_r",    r, 5);

        // 12 / 5 with a 9 / 2 request pulsed during CALC
        base = done_cnt;
        dif.start = 1'b1; dif.dividend = 4'd12; dif.divisor = 4'd5;
        tick();
        dif.start = 1'b0;
        tick();
        dif.start = 1'b1; dif.dividend = 4'd9; dif.divisor = 4'd2;
        tick();
        dif.start = 1'b0;
        check("t4_busy", dif.busy, 1);
        guard = 0;
        while (dif.done !== 1'b1 && guard < 20) begin tick(); guard++; end
        check("t4_done_seen", dif.done, 1);
        check("t4_q",   dif.quotient, 2);
        check("t4_r",   dif.remainder, 2);
        check("t4_dbz", dif.div_by_zero, 0);
        repeat (12) tick();
        check("t4_pulses", done_cnt - base, 1);

        // reset two cycles into CALC
        dif.start = 1'b1; dif.dividend = 4'd13; dif.divisor = 4'd3;
        tick();
        dif.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", dif.busy, 0);
        check("t5_done", dif.done, 0);
        check("t5_q",    dif.quotient, 0);
        check("t5_r",    dif.remainder, 0);
        check("t5_dbz",  dif.div_by_zero, 0);
        base = done_cnt;
        repeat (6) tick();
        check("t5_no_done", done_cnt - base, 0);
        do_op(4'd7, 4'd2, q, r, z, lat, bc);
        check("t5_lat", lat, 4);
        check("t5_q2",  q, 3);
        check("t5_r2",  r, 1);

        // sweep of all pairs, start held high
        tick();
        cyc      = 0;
        last_cyc = 0;
        dif.start    = 1'b1;
        dif.dividend = 4'd0;
        dif.divisor  = 4'd0;
        for (int i = 0; i < 256; i++) begin
            ni = i / 16;
            di = i % 16;
            guard = 0;
            do begin
                tick();
                cyc++;
                guard++;
            end while (dif.done !== 1'b1 && guard < 20);
            if (dif.done !== 1'b1) begin
                check("sw_timeout", 0, 1);
                break;
            end
            qi = int'(dif.quotient);
            ri = int'(dif.remainder);
            if (di != 0) begin
                check("sw_identity", qi * di + ri, ni);
                check("sw_r_lt_d", (ri < di) ? 1 : 0, 1);
                check("sw_dbz", dif.div_by_zero, 0);
            end else begin
                check("sw_dbz", dif.div_by_zero, 1);
                check("sw_dbz_q", qi, 15);
                check("sw_dbz_r", ri, ni);
            end
            if (i > 0) check("sw_spacing", cyc - last_cyc, (di == 0) ? 2 : WIDTH + 2);
            last_cyc = cyc;
            if (i < 255) begin
                dif.dividend = 4'((i + 1) / 16);
                dif.divisor  = 4'((i + 1) % 16);
            end
        end
        dif.start = 1'b0;
        repeat (4) tick();

        check("done_busy_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
